// File: rtl/car_lane_controller_if.sv
// Bus between the lane controller and its surroundings: frame/game control in,
// car X positions, direction flags and the update-done pulse out.
interface car_lane_controller_if;
   logic       i_Frame_Tick;
   logic       i_Enable;
   logic       i_Restart;
   logic [1:0] i_Level;
   logic [9:0] o_Car_1X_Position;
   logic [9:0] o_Car_2X_Position;
   logic [9:0] o_Car_3X_Position;
   logic [9:0] o_Car_4X_Position;
   logic [3:0] o_Reverse;
   logic       o_Update_Done;

   modport master (
      output i_Frame_Tick, i_Enable, i_Restart, i_Level,
      input  o_Car_1X_Position, o_Car_2X_Position, o_Car_3X_Position,
             o_Car_4X_Position, o_Reverse, o_Update_Done
   );

   modport slave (
      input  i_Frame_Tick, i_Enable, i_Restart, i_Level,
      output o_Car_1X_Position, o_Car_2X_Position, o_Car_3X_Position,
             o_Car_4X_Position, o_Reverse, o_Update_Done
   );
endinterface

// File: rtl/car_lane_controller.sv
// Four-lane car position generator: on each frame tick a small FSM walks the lanes
// in turn during vertical blanking, stepping each car when its level-scaled divider expires.
module car_lane_controller #(
   parameter int          H_VISIBLE_AREA = 640,
   parameter int          CAR_STEP       = 4,
   parameter logic [31:0] LANE_PERIODS   = {8'd4, 8'd3, 8'd2, 8'd1},
   parameter logic [39:0] INIT_X         = {10'd480, 10'd320, 10'd160, 10'd0},
   parameter logic [3:0]  LANE_REVERSE   = 4'b1010
) (
   input logic                  i_Clk,
   input logic                  i_Rst_N,
   car_lane_controller_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LANE0, LANE1, LANE2, LANE3, DONE} state_t;

   state_t     state_q, state_d;
   logic [9:0] pos_q [4];
   logic [9:0] pos_d [4];
   logic [7:0] cnt_q [4];
   logic [7:0] cnt_d [4];
   logic [3:0] rev_q, rev_d;
   logic       done_q, done_d;

   logic       lane_active;
   logic [1:0] lane_sel;
   logic [7:0] eff;
   logic [8:0] cnt_inc;

   // Wrapping one-step move; intermediates are 11 bits so x + H never overflows.
   function automatic logic [9:0] next_pos(input logic [9:0] x, input logic rev);
      logic [10:0] xw;
      logic [10:0] sum;
      xw  = {1'b0, x};
      sum = xw + 11'(CAR_STEP);
      if (rev) begin
         if (xw < 11'(CAR_STEP)) next_pos = 10'(xw + 11'(H_VISIBLE_AREA) - 11'(CAR_STEP));
         else                    next_pos = 10'(xw - 11'(CAR_STEP));
      end else begin
         if (sum >= 11'(H_VISIBLE_AREA)) next_pos = 10'(sum - 11'(H_VISIBLE_AREA));
         else                            next_pos = sum[9:0];
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      cnt_d       = cnt_q;
      rev_d       = rev_q;
      done_d      = 1'b0;
      lane_active = 1'b0;
      lane_sel    = 2'd0;
      eff         = 8'd1;
      cnt_inc     = 9'd0;

      case (state_q)
         IDLE:    if (bus.i_Frame_Tick && bus.i_Enable) state_d = LANE0;
         LANE0:   begin lane_active = 1'b1; lane_sel = 2'd0; state_d = LANE1; end
         LANE1:   begin lane_active = 1'b1; lane_sel = 2'd1; state_d = LANE2; end
         LANE2:   begin lane_active = 1'b1; lane_sel = 2'd2; state_d = LANE3; end
         LANE3:   begin lane_active = 1'b1; lane_sel = 2'd3; state_d = DONE; done_d = 1'b1; end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A zero effective period (base shifted out by a high level) still moves every frame.
      if (lane_active) begin
         eff = LANE_PERIODS[8*lane_sel +: 8] >> bus.i_Level;
         if (eff == 8'd0) eff = 8'd1;
         cnt_inc = {1'b0, cnt_q[lane_sel]} + 9'd1;
         if (cnt_inc >= {1'b0, eff}) begin
            pos_d[lane_sel] = next_pos(pos_q[lane_sel], LANE_REVERSE[lane_sel]);
            cnt_d[lane_sel] = 8'd0;
         end else begin
            cnt_d[lane_sel] = cnt_inc[7:0];
         end
      end

      if (bus.i_Restart) begin
         state_d = IDLE;
         done_d  = 1'b0;
         for (int i = 0; i < 4; i++) begin
            pos_d[i] = INIT_X[10*i +: 10];
            cnt_d[i] = 8'd0;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_N) begin
      if (!i_Rst_N) begin
         state_q <= IDLE;
         rev_q   <= LANE_REVERSE;
         done_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            pos_q[i] <= INIT_X[10*i +: 10];
            cnt_q[i] <= 8'd0;
         end
      end else begin
         state_q <= state_d;
         rev_q   <= rev_d;
         done_q  <= done_d;
         for (int i = 0; i < 4; i++) begin
            pos_q[i] <= pos_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.o_Car_1X_Position = pos_q[0];
   assign bus.o_Car_2X_Position = pos_q[1];
   assign bus.o_Car_3X_Position = pos_q[2];
   assign bus.o_Car_4X_Position = pos_q[3];
   assign bus.o_Reverse         = rev_q;
   assign bus.o_Update_Done     = done_q;

endmodule

// File: tb/tb_car_lane_controller.sv
// Directed-vector bench for car_lane_controller: frame ticks, wraps, levels,
// ignored ticks, enable gating, restart and asynchronous reset.
module tb_car_lane_controller;

   logic i_Clk = 1'b0;
   logic i_Rst_N;

   car_lane_controller_if lane_if ();

   car_lane_controller dut (
      .i_Clk   (i_Clk),
      .i_Rst_N (i_Rst_N),
      .bus     (lane_if.slave)
   );

   always #5 i_Clk = ~i_Clk;

   int vectors_applied = 0;
   int miscompares     = 0;
   int done_seen;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors_applied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Inputs change right after a falling edge and are sampled on the next rising edge.
   task automatic applyStimulus(input logic tick, input logic enable, input logic restart, input logic [1:0] level);
      lane_if.i_Frame_Tick = tick;
      lane_if.i_Enable     = enable;
      lane_if.i_Restart    = restart;
      lane_if.i_Level      = level;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_Clk);
         @(negedge i_Clk);
      end
   endtask

   task automatic stepCountDone(input int n);
      repeat (n) begin
         @(posedge i_Clk);
         @(negedge i_Clk);
         if (lane_if.o_Update_Done) done_seen++;
      end
   endtask

   task automatic runFrame(input logic [1:0] level);
      applyStimulus(1'b1, 1'b1, 1'b0, level);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, level);
      step(5);
   endtask

   task automatic doRestart();
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
   endtask

   task automatic checkPositions(input string tag, input int e0, input int e1, input int e2, input int e3);
      checkOutput({tag, "_car1"}, 32'(lane_if.o_Car_1X_Position), 32'(e0));
      checkOutput({tag, "_car2"}, 32'(lane_if.o_Car_2X_Position), 32'(e1));
      checkOutput({tag, "_car3"}, 32'(lane_if.o_Car_3X_Position), 32'(e2));
      checkOutput({tag, "_car4"}, 32'(lane_if.o_Car_4X_Position), 32'(e3));
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      i_Rst_N = 1'b0;
      step(2);
      i_Rst_N = 1'b1;
      step(1);

      // Reset values
      checkPositions("reset", 0, 160, 320, 480);
      checkOutput("reset_reverse", 32'(lane_if.o_Reverse), 32'(4'b1010));
      checkOutput("reset_done", 32'(lane_if.o_Update_Done), 0);

      // One tick at level 0, watching each lane slot and the done pulse
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      checkOutput("t1_lane0_before", 32'(lane_if.o_Car_1X_Position), 0);
      step(1);
      checkOutput("t1_lane0_moved", 32'(lane_if.o_Car_1X_Position), 4);
      step(1);
      checkOutput("t1_lane1_hold", 32'(lane_if.o_Car_2X_Position), 160);
      step(1);
      checkOutput("t1_done_early", 32'(lane_if.o_Update_Done), 0);
      step(1);
      checkOutput("t1_done_pulse", 32'(lane_if.o_Update_Done), 1);
      step(1);
      checkOutput("t1_done_clear", 32'(lane_if.o_Update_Done), 0);
      checkPositions("t1_end", 4, 160, 320, 480);
      runFrame(2'd0);
      checkPositions("t2_end", 8, 156, 320, 480);

      // Long run from restart to exercise both wrap directions
      doRestart();
      repeat (80) runFrame(2'd0);
      checkPositions("k80", 320, 0, 424, 400);
      repeat (2) runFrame(2'd0);
      checkPositions("k82_revwrap", 328, 636, 428, 400);
      repeat (77) runFrame(2'd0);
      checkOutput("k159_car1", 32'(lane_if.o_Car_1X_Position), 636);
      runFrame(2'd0);
      checkPositions("k160_fwdwrap", 0, 480, 532, 320);

      // Level scaling of the dividers
      doRestart();
      runFrame(2'd1);
      checkPositions("lvl1", 4, 156, 324, 480);
      doRestart();
      runFrame(2'd2);
      checkPositions("lvl2", 4, 156, 324, 476);
      runFrame(2'd3);
      checkPositions("lvl3", 8, 152, 328, 472);

      // Tick during a running sequence is dropped, not queued
      doRestart();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      step(9);
      checkPositions("midtick", 4, 160, 320, 480);

      // Disabled tick does nothing
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      done_seen = 0;
      stepCountDone(6);
      checkOutput("disabled_done", 32'(done_seen), 0);
      checkOutput("disabled_car1", 32'(lane_if.o_Car_1X_Position), 4);

      // Dropping enable mid-sequence lets the sequence finish
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
      done_seen = 0;
      stepCountDone(5);
      checkOutput("enoff_done", 32'(done_seen), 1);
      checkPositions("enoff", 8, 156, 320, 480);

      // Restart in the middle of a sequence
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      step(1);
      checkOutput("rst_mid_car1_moved", 32'(lane_if.o_Car_1X_Position), 12);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
      step(1);
      checkPositions("rst_mid", 0, 160, 320, 480);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      done_seen = 0;
      stepCountDone(5);
      checkOutput("rst_mid_done", 32'(done_seen), 0);
      runFrame(2'd0);
      checkPositions("rst_cnt_clear", 4, 160, 320, 480);

      // Restart together with a tick drops the tick
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      done_seen = 0;
      stepCountDone(6);
      checkOutput("rst_tick_done", 32'(done_seen), 0);
      checkOutput("rst_tick_car1", 32'(lane_if.o_Car_1X_Position), 0);

      // Asynchronous reset mid-sequence takes effect without a clock edge
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      step(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
      step(2);
      checkOutput("arst_car1_before", 32'(lane_if.o_Car_1X_Position), 4);
      @(posedge i_Clk);
      #2 i_Rst_N = 1'b0;
      #1;
      checkPositions("arst", 0, 160, 320, 480);
      checkOutput("arst_done", 32'(lane_if.o_Update_Done), 0);
      checkOutput("arst_reverse", 32'(lane_if.o_Reverse), 32'(4'b1010));
      @(negedge i_Clk);
      i_Rst_N = 1'b1;
      done_seen = 0;
      stepCountDone(6);
      checkOutput("arst_after_done", 32'(done_seen), 0);
      checkOutput("arst_after_car4", 32'(lane_if.o_Car_4X_Position), 480);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
